// File: rtl/pipo_arb_pkg.sv
// Shared definitions for the PIPO access arbiter: FSM state encoding and
// default sizing parameters.
package pipo_arb_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned NREQ_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_SETTLE  = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

endpackage

// File: rtl/pipo_access_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Ports: req   - request vector
//        ptr   - index of the highest-priority requester this round
//        found - at least one request is present
//        sel   - one-hot winner
//        idx   - winner index
module rr_pick
   import pipo_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            found,
   output logic [NREQ-1:0] sel,
   output logic [IW-1:0]   idx
);

   // Walk ptr, ptr+1, ... wrapping at NREQ; first asserted request wins.
   always_comb begin
      logic [31:0] cand;
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr) + k) % NREQ;
         if (!found && req[IW'(cand)]) begin
            found           = 1'b1;
            sel[IW'(cand)]  = 1'b1;
            idx             = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/pipo_access_arbiter.sv
// pipo_access_arbiter: round-robin access controller for the shared PIPO
// holding register. Sequences each write as LOAD -> SETTLE -> CAPTURE and
// returns the captured value with a one-cycle acknowledge.
// Ports: clk, rst        - clock, synchronous active-high reset
//        req, req_data   - per-requester request and write data
//        gnt, ack        - one-hot grant (LOAD..CAPTURE), completion pulse
//        rd_data, err    - captured value, capture/write mismatch pulse
//        busy            - FSM not idle (decoded)
//        reg_in, reg_load, reg_out - holding register pins
module pipo_access_arbiter
   import pipo_arb_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned NREQ  = NREQ_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  err,
   output logic                  busy,
   output logic [WIDTH-1:0]      reg_in,
   output logic                  reg_load,
   input  logic [WIDTH-1:0]      reg_out
);

   localparam int unsigned IW = $clog2(NREQ);

   state_t             state, state_d;
   logic [IW-1:0]      ptr, ptr_d;
   logic [IW-1:0]      win, win_d;
   logic [WIDTH-1:0]   wdata, wdata_d;
   logic [NREQ-1:0]    gnt_d, ack_d;
   logic [WIDTH-1:0]   rd_data_d, reg_in_d;
   logic               err_d, reg_load_d;

   logic               pick_found;
   logic [NREQ-1:0]    pick_sel;
   logic [IW-1:0]      pick_idx;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .sel   (pick_sel),
      .idx   (pick_idx)
   );

   assign busy = (state != ST_IDLE);

   // Next state and next values of all registered outputs.
   always_comb begin
      state_d    = state;
      ptr_d      = ptr;
      win_d      = win;
      wdata_d    = wdata;
      gnt_d      = gnt;
      ack_d      = '0;
      err_d      = 1'b0;
      rd_data_d  = rd_data;
      reg_in_d   = reg_in;
      reg_load_d = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               // reg_in/reg_load are registered, so they are set up here to
               // be valid during the LOAD cycle.
               wdata_d    = req_data[pick_idx*WIDTH +: WIDTH];
               reg_in_d   = req_data[pick_idx*WIDTH +: WIDTH];
               reg_load_d = 1'b1;
               win_d      = pick_idx;
               gnt_d      = pick_sel;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            reg_in_d = wdata;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            reg_in_d = wdata;
            state_d  = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            rd_data_d = reg_out;
            err_d     = (reg_out != wdata);
            ack_d     = NREQ'(1) << win;
            gnt_d     = '0;
            ptr_d     = (32'(win) == NREQ - 1) ? '0 : win + IW'(1);
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         win      <= '0;
         wdata    <= '0;
         gnt      <= '0;
         ack      <= '0;
         err      <= 1'b0;
         rd_data  <= '0;
         reg_in   <= '0;
         reg_load <= 1'b0;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         win      <= win_d;
         wdata    <= wdata_d;
         gnt      <= gnt_d;
         ack      <= ack_d;
         err      <= err_d;
         rd_data  <= rd_data_d;
         reg_in   <= reg_in_d;
         reg_load <= reg_load_d;
      end
   end

endmodule

// File: tb/tb_pipo_access_arbiter.sv
// Self-checking bench for pipo_access_arbiter with a behavioural model of the
// PIPO holding register and a scoreboard of expected acknowledges.
module tb_pipo_access_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt, ack;
   logic [7:0]  rd_data;
   logic        err, busy;
   logic [7:0]  reg_in;
   logic        reg_load;
   logic [7:0]  reg_out;

   // Register model: load stores and drives 0, next cycle presents stored.
   logic [7:0]  model_stored, model_out;
   logic        fault;

   typedef struct {
      logic [3:0] ack;
      logic [7:0] data;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst) begin
         model_stored <= 8'h00;
         model_out    <= 8'h00;
      end else if (reg_load) begin
         model_stored <= reg_in;
         model_out    <= 8'h00;
      end else begin
         model_out    <= model_stored;
      end
   end

   assign reg_out = fault ? 8'h00 : model_out;

   pipo_access_arbiter #(.WIDTH(8), .NREQ(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .ack      (ack),
      .rd_data  (rd_data),
      .err      (err),
      .busy     (busy),
      .reg_in   (reg_in),
      .reg_load (reg_load),
      .reg_out  (reg_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Advance one cycle, sample outputs, score any acknowledge, and let the
   // acknowledged requester drop its request.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (ack !== 4'b0000) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("ack",       32'(ack),     32'(e.ack));
            chk("rd_data",   32'(rd_data), 32'(e.data));
            chk("err",       32'(err),     32'(e.err));
            chk("ack_cycle", 32'(cyc),     32'(e.cyc));
         end
         req = req & ~ack;
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [7:0] d, input logic e, input int c);
      exp_t x;
      x.ack = a; x.data = d; x.err = e; x.cyc = c;
      exp_q.push_back(x);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      int c0;
      rst = 1'b1; req = 4'b0; req_data = 32'h0; fault = 1'b0;
      step(); step();
      // Reset state
      chk("rst_gnt",      32'(gnt),      32'h0);
      chk("rst_ack",      32'(ack),      32'h0);
      chk("rst_err",      32'(err),      32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_rd_data",  32'(rd_data),  32'h0);
      chk("rst_reg_in",   32'(reg_in),   32'h0);
      chk("rst_reg_load", 32'(reg_load), 32'h0);
      rst = 1'b0;
      step();

      // All four at once from ptr=0: order 0,1,2,3, acks every 4 cycles.
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      c0 = cyc;
      push(4'b0001, 8'h11, 1'b0, c0 + 4);
      push(4'b0010, 8'h22, 1'b0, c0 + 8);
      push(4'b0100, 8'h33, 1'b0, c0 + 12);
      push(4'b1000, 8'h44, 1'b0, c0 + 16);
      step();
      chk("all_gnt0", 32'(gnt), 32'h1);
      drain(40);
      step();
      chk("all_ack_clear", 32'(ack), 32'h0);
      chk("all_idle", 32'(busy), 32'h0);

      // Single request on requester 1 (ptr now 0).
      req_data = 32'h0000_A500;
      req = 4'b0010;
      c0 = cyc;
      push(4'b0010, 8'hA5, 1'b0, c0 + 4);
      step();
      chk("single_load",   32'(reg_load), 32'h1);
      chk("single_reg_in", 32'(reg_in),   32'hA5);
      chk("single_gnt",    32'(gnt),      32'h2);
      chk("single_busy",   32'(busy),     32'h1);
      step();
      chk("single_settle_load", 32'(reg_load), 32'h0);
      req_data = 32'hDEAD_BEEF;
      drain(10);

      // Serve requester 2, then 0 beats 2 because ptr=3 wraps to 0.
      req_data = 32'h0077_0000;
      req = 4'b0100;
      c0 = cyc;
      push(4'b0100, 8'h77, 1'b0, c0 + 4);
      drain(10);
      step();
      req_data = 32'h0002_0001;
      req = 4'b0101;
      c0 = cyc;
      push(4'b0001, 8'h01, 1'b0, c0 + 4);
      push(4'b0100, 8'h02, 1'b0, c0 + 8);
      step();
      chk("fair_gnt", 32'(gnt), 32'h1);
      drain(20);
      step();

      // Request dropped in LOAD still completes.
      req_data = 32'h3C00_0000;
      req = 4'b1000;
      c0 = cyc;
      push(4'b1000, 8'h3C, 1'b0, c0 + 4);
      step();
      req = 4'b0000;
      drain(10);
      step();

      // Register returns 0 for write data 0xFF: err flagged.
      fault = 1'b1;
      req_data = 32'h0000_00FF;
      req = 4'b0001;
      c0 = cyc;
      push(4'b0001, 8'h00, 1'b1, c0 + 4);
      drain(10);
      fault = 1'b0;
      step();
      chk("err_pulse_clear", 32'(err), 32'h0);

      // Reset during SETTLE aborts without ack.
      req_data = 32'h0000_5A00;
      req = 4'b0010;
      step();
      step();
      chk("abort_in_settle", 32'(busy), 32'h1);
      rst = 1'b1;
      req = 4'b0000;
      step();
      chk("abort_busy",     32'(busy),     32'h0);
      chk("abort_gnt",      32'(gnt),      32'h0);
      chk("abort_ack",      32'(ack),      32'h0);
      chk("abort_reg_load", 32'(reg_load), 32'h0);
      chk("abort_reg_in",   32'(reg_in),   32'h0);
      chk("abort_rd_data",  32'(rd_data),  32'h0);
      rst = 1'b0;
      repeat (5) step();
      req_data = 32'h0000_9900;
      req = 4'b0010;
      c0 = cyc;
      push(4'b0010, 8'h99, 1'b0, c0 + 4);
      drain(10);
      step();
      chk("final_idle", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
